// File: rtl/nco_voice_scheduler_pkg.sv
// Shared types and defaults for the NCO voice scheduler slice.
package nco_pkg;

  localparam int NUM_VOICES_DEF = 8;
  localparam int PHASE_W_DEF    = 24;

  typedef logic [$clog2(NUM_VOICES_DEF)-1:0] voice_idx_t;
  typedef logic [PHASE_W_DEF-1:0]            phase_t;

  // Scheduler sweep states. IDLE waits for the sample strobe, SWEEP walks
  // every voice through the shared adder, DONE emits the frame pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/nco_voice_scheduler_if.sv
// Bundle of strobe, config and result signals between the NCO scheduler and
// its controller / downstream wavetable-mixer.
//
// Transfer semantics: there is no back-pressure. A result (out_voice,
// out_phase, out_gate) is transferred on every master_clk cycle in which
// out_valid is high; the consumer must accept it in that cycle. Config writes
// and the sample strobe are likewise accepted on any cycle they are high.
interface nco_voice_scheduler_if #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24
);
  import nco_pkg::*;

  localparam int IDX_W = $clog2(NUM_VOICES);

  // Controller -> scheduler
  logic               sample_clk_en;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_voice;
  logic [PHASE_W-1:0] cfg_inc;
  logic               cfg_gate;
  logic               ovr_clr;

  // Scheduler -> controller / downstream
  logic               out_valid;
  logic [IDX_W-1:0]   out_voice;
  logic [PHASE_W-1:0] out_phase;
  logic               out_gate;
  logic               frame_done;
  logic               busy;
  logic               overrun;
  sched_state_t       dbg_state;

  // Controller / test side
  modport master (
    output sample_clk_en, cfg_we, cfg_voice, cfg_inc, cfg_gate, ovr_clr,
    input  out_valid, out_voice, out_phase, out_gate, frame_done, busy,
           overrun, dbg_state
  );

  // Scheduler side
  modport slave (
    input  sample_clk_en, cfg_we, cfg_voice, cfg_inc, cfg_gate, ovr_clr,
    output out_valid, out_voice, out_phase, out_gate, frame_done, busy,
           overrun, dbg_state
  );

endinterface

// File: rtl/nco_voice_scheduler_regfile.sv
// Per-voice register file: phase increment, gate and phase accumulator.
// One config write port and one read-modify-write port used by the sweep.
// When both hit the same voice in one cycle the sweep sees the old inc/gate,
// the write lands in inc/gate, and a gate-off write's phase clear beats the
// accumulate.
module nco_voice_regfile #(
  parameter  int NUM_VOICES = 8,
  parameter  int PHASE_W    = 24,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst,
  // config write port
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [PHASE_W-1:0] wr_inc,
  input  logic               wr_gate,
  // sweep read-modify-write port
  input  logic               sw_en,
  input  logic [IDX_W-1:0]   sw_idx,
  output logic               sw_gate,
  output logic [PHASE_W-1:0] sw_phase
);

  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic                  wr_hit;

  // Out-of-range voice indices are dropped without touching any register.
  assign wr_hit = wr_en && (int'(wr_idx) < NUM_VOICES);

  // Sweep read: new phase is the old phase plus inc when gated, wrapping
  // modulo 2^PHASE_W; ungated voices report their held phase.
  always_comb begin
    sw_gate  = gate_q[sw_idx];
    sw_phase = phase_q[sw_idx] + (gate_q[sw_idx] ? inc_q[sw_idx] : '0);
  end

  // Register update: accumulate first, config write afterwards so a phase
  // clear on the same voice takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        inc_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      if (sw_en && gate_q[sw_idx]) begin
        phase_q[sw_idx] <= sw_phase;
      end
      if (wr_hit) begin
        inc_q[wr_idx]  <= wr_inc;
        gate_q[wr_idx] <= wr_gate;
        if (!wr_gate) begin
          phase_q[wr_idx] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/nco_voice_scheduler.sv
// Time-multiplexed phase accumulator scheduler. Each sample strobe launches
// one sweep that pushes every voice through the shared adder, one voice per
// master_clk cycle, streaming (voice, phase, gate) results and pulsing
// frame_done after the last voice.
module nco_voice_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF
) (
  input  logic                   master_clk,
  input  logic                   rst,
  nco_voice_scheduler_if.slave   bus
);

  localparam int               IDX_W    = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  sched_state_t       state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;

  logic               out_valid_q, out_valid_n;
  logic [IDX_W-1:0]   out_voice_q, out_voice_n;
  logic [PHASE_W-1:0] out_phase_q, out_phase_n;
  logic               out_gate_q,  out_gate_n;
  logic               frame_done_q, frame_done_n;
  logic               overrun_q,   overrun_n;

  logic               sw_en;
  logic               sw_gate;
  logic [PHASE_W-1:0] sw_phase;

  nco_voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_regfile (
    .clk      (master_clk),
    .rst      (rst),
    .wr_en    (bus.cfg_we),
    .wr_idx   (bus.cfg_voice),
    .wr_inc   (bus.cfg_inc),
    .wr_gate  (bus.cfg_gate),
    .sw_en    (sw_en),
    .sw_idx   (idx),
    .sw_gate  (sw_gate),
    .sw_phase (sw_phase)
  );

  // State, index and output registers.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      out_phase_q  <= '0;
      out_gate_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      out_valid_q  <= out_valid_n;
      out_voice_q  <= out_voice_n;
      out_phase_q  <= out_phase_n;
      out_gate_q   <= out_gate_n;
      frame_done_q <= frame_done_n;
      overrun_q    <= overrun_n;
    end
  end

  // Next-state, sweep control and next-output logic.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    out_valid_n  = 1'b0;
    out_voice_n  = out_voice_q;
    out_phase_n  = out_phase_q;
    out_gate_n   = out_gate_q;
    frame_done_n = 1'b0;
    overrun_n    = overrun_q;
    sw_en        = 1'b0;

    case (state)
      IDLE: begin
        if (bus.sample_clk_en) begin
          state_n = SWEEP;
          idx_n   = '0;
        end
      end
      SWEEP: begin
        sw_en       = 1'b1;
        out_valid_n = 1'b1;
        out_voice_n = idx;
        out_phase_n = sw_phase;
        out_gate_n  = sw_gate;
        if (idx == LAST_IDX) begin
          state_n = DONE;
          idx_n   = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      DONE: begin
        frame_done_n = 1'b1;
        state_n      = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A strobe outside IDLE (including the DONE->IDLE edge) is dropped and
    // flagged; setting beats a simultaneous clear.
    if (bus.ovr_clr) begin
      overrun_n = 1'b0;
    end
    if (bus.sample_clk_en && (state != IDLE)) begin
      overrun_n = 1'b1;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_voice  = out_voice_q;
  assign bus.out_phase  = out_phase_q;
  assign bus.out_gate   = out_gate_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != IDLE);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Self-checking bench for nco_voice_scheduler: an 8-voice instance for the
// main behaviour and a 6-voice instance for out-of-range config writes.
module tb_nco_voice_scheduler;
  import nco_pkg::*;

  localparam int NV  = 8;
  localparam int NVB = 6;
  localparam int PW  = 24;
  localparam int IW  = 3;
  localparam int W   = IW + 1 + PW;

  // ---------------- clock / reset ----------------
  logic master_clk = 1'b0;
  logic rst        = 1'b1;
  always #5 master_clk = ~master_clk;

  nco_voice_scheduler_if #(.NUM_VOICES(NV),  .PHASE_W(PW)) bus_a ();
  nco_voice_scheduler_if #(.NUM_VOICES(NVB), .PHASE_W(PW)) bus_b ();

  nco_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW)) dut_a (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (bus_a)
  );

  nco_voice_scheduler #(.NUM_VOICES(NVB), .PHASE_W(PW)) dut_b (
    .master_clk (master_clk),
    .rst        (rst),
    .bus        (bus_b)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qb[$];
  int valid_cnt_a = 0, fd_cnt_a = 0;
  int valid_cnt_b = 0, fd_cnt_b = 0;

  // Reference model of the 8-voice register file
  logic [PW-1:0] m_inc   [NV];
  logic [PW-1:0] m_phase [NV];
  logic          m_gate  [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: result with empty expected queue", name);
  endtask

  function automatic logic [W-1:0] pack(input int v, input logic g, input logic [PW-1:0] p);
    logic [IW-1:0] vv;
    vv = v[IW-1:0];
    return {vv, g, p};
  endfunction

  // ---------------- monitors ----------------
  initial begin : mon_a
    int run;
    logic [W-1:0] e;
    run = 0;
    forever begin
      @(negedge master_clk);
      if (rst) begin
        run = 0;
      end else if (bus_a.out_valid) begin
        valid_cnt_a++;
        run++;
        check("a_fd_during_valid", bus_a.frame_done, 0);
        if (exp_q.size() == 0) fail_now("a_unexpected_valid");
        else begin
          e = exp_q.pop_front();
          check("a_result", {bus_a.out_voice, bus_a.out_gate, bus_a.out_phase}, e);
        end
      end else begin
        if (bus_a.frame_done) begin
          fd_cnt_a++;
          check("a_fd_after_run", run, NV);
        end
        run = 0;
      end
    end
  end

  initial begin : mon_b
    int run;
    logic [W-1:0] e;
    run = 0;
    forever begin
      @(negedge master_clk);
      if (rst) begin
        run = 0;
      end else if (bus_b.out_valid) begin
        valid_cnt_b++;
        run++;
        if (exp_qb.size() == 0) fail_now("b_unexpected_valid");
        else begin
          e = exp_qb.pop_front();
          check("b_result", {bus_b.out_voice, bus_b.out_gate, bus_b.out_phase}, e);
        end
      end else begin
        if (bus_b.frame_done) begin
          fd_cnt_b++;
          check("b_fd_after_run", run, NVB);
        end
        run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_inc[i] = '0; m_phase[i] = '0; m_gate[i] = 1'b0;
    end
  endtask

  task automatic model_write(input int v, input logic [PW-1:0] inc, input logic g);
    m_inc[v]  = inc;
    m_gate[v] = g;
    if (!g) m_phase[v] = '0;
  endtask

  // Push expected results for voices 0..last and advance the model phases.
  task automatic push_sweep_a(input int last);
    for (int v = 0; v <= last; v++) begin
      if (m_gate[v]) m_phase[v] = m_phase[v] + m_inc[v];
      exp_q.push_back(pack(v, m_gate[v], m_phase[v]));
    end
  endtask

  task automatic cfg_a(input int v, input logic [PW-1:0] inc, input logic g);
    @(negedge master_clk);
    bus_a.cfg_we = 1'b1; bus_a.cfg_voice = v[IW-1:0];
    bus_a.cfg_inc = inc; bus_a.cfg_gate = g;
    @(negedge master_clk);
    bus_a.cfg_we = 1'b0;
    model_write(v, inc, g);
  endtask

  // One sweep. coll_v >= 0 writes that voice in the cycle it is swept;
  // en_k > 0 pulses another strobe (optionally with ovr_clr) at sweep edge k.
  task automatic sweep_a(input int coll_v, input logic [PW-1:0] c_inc, input logic c_gate,
                         input int en_k, input logic clr_k);
    int v0, f0;
    v0 = valid_cnt_a; f0 = fd_cnt_a;
    push_sweep_a(NV - 1);
    if (coll_v >= 0) model_write(coll_v, c_inc, c_gate);
    @(negedge master_clk);
    bus_a.sample_clk_en = 1'b1;
    for (int k = 1; k <= NV + 1; k++) begin
      @(negedge master_clk);
      if (k == 1) check("a_busy_in_sweep", bus_a.busy, 1);
      bus_a.sample_clk_en = (k == en_k);
      bus_a.ovr_clr       = clr_k && (k == en_k);
      bus_a.cfg_we        = (coll_v >= 0) && (k == coll_v + 1);
      bus_a.cfg_voice     = coll_v[IW-1:0];
      bus_a.cfg_inc       = c_inc;
      bus_a.cfg_gate      = c_gate;
    end
    @(negedge master_clk);
    bus_a.sample_clk_en = 1'b0; bus_a.ovr_clr = 1'b0; bus_a.cfg_we = 1'b0;
    repeat (3) @(negedge master_clk);
    check("a_valid_count", valid_cnt_a - v0, NV);
    check("a_frame_count", fd_cnt_a - f0, 1);
    check("a_busy_idle", bus_a.busy, 0);
  endtask

  task automatic clear_ovr_a();
    @(negedge master_clk);
    bus_a.ovr_clr = 1'b1;
    @(negedge master_clk);
    bus_a.ovr_clr = 1'b0;
    check("a_overrun_cleared", bus_a.overrun, 0);
  endtask

  task automatic reset_mid_sweep_a();
    int v0, f0;
    v0 = valid_cnt_a; f0 = fd_cnt_a;
    push_sweep_a(3);
    @(negedge master_clk);
    bus_a.sample_clk_en = 1'b1;
    @(negedge master_clk);
    bus_a.sample_clk_en = 1'b0;
    repeat (3) @(negedge master_clk);
    @(negedge master_clk);
    #1 rst = 1'b1;
    @(negedge master_clk);
    check("rst_out_valid",  bus_a.out_valid, 0);
    check("rst_out_voice",  bus_a.out_voice, 0);
    check("rst_out_phase",  bus_a.out_phase, 0);
    check("rst_out_gate",   bus_a.out_gate, 0);
    check("rst_frame_done", bus_a.frame_done, 0);
    check("rst_busy",       bus_a.busy, 0);
    check("rst_overrun",    bus_a.overrun, 0);
    check("rst_state",      bus_a.dbg_state, IDLE);
    #1 rst = 1'b0;
    model_reset();
    repeat (NV + 3) @(negedge master_clk);
    check("rst_partial_valids", valid_cnt_a - v0, 4);
    check("rst_no_frame_done",  fd_cnt_a - f0, 0);
  endtask

  task automatic cfg_b(input int v, input logic [PW-1:0] inc, input logic g);
    @(negedge master_clk);
    bus_b.cfg_we = 1'b1; bus_b.cfg_voice = v[IW-1:0];
    bus_b.cfg_inc = inc; bus_b.cfg_gate = g;
    @(negedge master_clk);
    bus_b.cfg_we = 1'b0;
  endtask

  // Expected: only voice 1 is gated, with phase v1_phase; all others 0.
  task automatic sweep_b(input logic [PW-1:0] v1_phase);
    int v0, f0;
    v0 = valid_cnt_b; f0 = fd_cnt_b;
    for (int v = 0; v < NVB; v++)
      exp_qb.push_back(pack(v, (v == 1), (v == 1) ? v1_phase : '0));
    @(negedge master_clk);
    bus_b.sample_clk_en = 1'b1;
    @(negedge master_clk);
    bus_b.sample_clk_en = 1'b0;
    repeat (NVB + 4) @(negedge master_clk);
    check("b_valid_count", valid_cnt_b - v0, NVB);
    check("b_frame_count", fd_cnt_b - f0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus_a.sample_clk_en = 0; bus_a.cfg_we = 0; bus_a.cfg_voice = '0;
    bus_a.cfg_inc = '0; bus_a.cfg_gate = 0; bus_a.ovr_clr = 0;
    bus_b.sample_clk_en = 0; bus_b.cfg_we = 0; bus_b.cfg_voice = '0;
    bus_b.cfg_inc = '0; bus_b.cfg_gate = 0; bus_b.ovr_clr = 0;
    model_reset();

    repeat (3) @(negedge master_clk);
    check("reset_out_valid",  bus_a.out_valid, 0);
    check("reset_out_phase",  bus_a.out_phase, 0);
    check("reset_frame_done", bus_a.frame_done, 0);
    check("reset_busy",       bus_a.busy, 0);
    check("reset_overrun",    bus_a.overrun, 0);
    check("reset_state",      bus_a.dbg_state, IDLE);
    #1 rst = 1'b0;

    // Basic sweep: voice0 inc 0x100 -> 0x000100, others 0
    cfg_a(0, 24'h000100, 1'b1);
    sweep_a(-1, '0, 1'b0, 0, 1'b0);

    // Wrap-around: voice3 0x800000, 0x000000, 0x800000
    cfg_a(3, 24'h800000, 1'b1);
    repeat (3) sweep_a(-1, '0, 1'b0, 0, 1'b0);

    // Overrun mid-sweep, clear, then set+clear together
    sweep_a(-1, '0, 1'b0, 3, 1'b0);
    check("ovr_set_mid_sweep", bus_a.overrun, 1);
    clear_ovr_a();
    sweep_a(-1, '0, 1'b0, 4, 1'b1);
    check("ovr_set_beats_clr", bus_a.overrun, 1);
    clear_ovr_a();

    // Collision: voice2 inc 0x10 -> phase 0x50, then write inc 0x20 gate 1
    cfg_a(2, 24'h000010, 1'b1);
    repeat (5) sweep_a(-1, '0, 1'b0, 0, 1'b0);
    sweep_a(2, 24'h000020, 1'b1, 0, 1'b0);  // voice2 out 0x60
    sweep_a(-1, '0, 1'b0, 0, 1'b0);         // voice2 out 0x80
    // Collision with gate-off: out 0x60, stored 0, next out 0 gate 0
    cfg_a(2, 24'h000010, 1'b0);
    cfg_a(2, 24'h000010, 1'b1);
    repeat (5) sweep_a(-1, '0, 1'b0, 0, 1'b0);
    sweep_a(2, 24'h000020, 1'b0, 0, 1'b0);
    sweep_a(-1, '0, 1'b0, 0, 1'b0);

    // Strobe on the DONE->IDLE edge is an overrun, not a new sweep
    sweep_a(-1, '0, 1'b0, NV + 1, 1'b0);
    check("ovr_on_done_edge", bus_a.overrun, 1);

    // Reset in the middle of a sweep, then a clean sweep from voice 0
    reset_mid_sweep_a();
    sweep_a(-1, '0, 1'b0, 0, 1'b0);

    // Six-voice instance: writes to voices 6 and 7 must be ignored
    cfg_b(1, 24'h000005, 1'b1);
    cfg_b(7, 24'h000123, 1'b1);
    cfg_b(6, 24'h000456, 1'b1);
    sweep_b(24'h000005);
    cfg_b(7, 24'h000000, 1'b0);
    cfg_b(6, 24'h000000, 1'b0);
    sweep_b(24'h00000A);

    check("a_queue_drained", exp_q.size(), 0);
    check("b_queue_drained", exp_qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nco_voice_scheduler.md
Name: nco_voice_scheduler

Overview:
Time-multiplexes one shared phase-accumulator adder across NUM_VOICES synth voices.
Each 48 kHz sample_clk_en pulse from the clock divider starts one sweep. The sweep steps every voice through the adder, one voice per master_clk cycle.
The block streams (voice, phase) results to the downstream wavetable/mixer and pulses frame_done when a sweep completes.
It also owns the per-voice configuration registers: phase increment and gate.

Parameters:
NUM_VOICES, 8, number of time-multiplexed voices (2..64)
PHASE_W, 24, phase accumulator and increment width in bits

Ports:
master_clk  in  1  24.576 MHz master clock
rst  in  1  synchronous, active-high reset
sample_clk_en  in  1  one-cycle 48 kHz strobe from clock divider; starts a sweep
cfg_we  in  1  config write strobe
cfg_voice  in  $clog2(NUM_VOICES)  voice index for write
cfg_inc  in  PHASE_W  phase increment to store
cfg_gate  in  1  voice enable to store
ovr_clr  in  1  clears overrun flag
out_valid  out  1  out_voice/out_phase/out_gate valid this cycle
out_voice  out  $clog2(NUM_VOICES)  voice index of current result
out_phase  out  PHASE_W  updated phase of that voice
out_gate  out  1  gate of that voice
frame_done  out  1  one-cycle pulse after last voice of a sweep
busy  out  1  high while state != IDLE
overrun  out  1  sticky: sample_clk_en arrived while busy

Behaviour:
- Reset values: all outputs 0; all inc, gate and phase registers 0; state IDLE; idx 0.
- Reset mid-sweep aborts the sweep. No frame_done is produced for the aborted sweep.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - sample_clk_en=1 at edge E0 -> SWEEP, idx<=0.
  - All other cycles stay IDLE; out_valid=0.
- SWEEP, at edge Ek (k=1..NUM_VOICES), with idx=k-1:
  - If gate[idx]=1: phase[idx] <= phase[idx]+inc[idx], modulo 2^PHASE_W (wrap silently, no carry out).
  - If gate[idx]=0: phase unchanged.
  - Registered outputs: out_valid<=1, out_voice<=idx, out_phase<=new phase value, out_gate<=gate[idx].
  - idx<=idx+1. At idx==NUM_VOICES-1 -> DONE.
- DONE: at the next edge, frame_done<=1 for exactly one cycle, out_valid<=0, -> IDLE.
- Timing summary:
  - out_valid is high for exactly NUM_VOICES consecutive cycles, starting one cycle after E0.
  - frame_done follows the last valid cycle directly.
  - Total sweep occupancy is NUM_VOICES+2 cycles, well under the 512-cycle sample period.
- busy = (state != IDLE), combinational from the state register.
- Overrun:
  - sample_clk_en=1 while state != IDLE sets overrun<=1 and is otherwise ignored; no sweep is restarted or queued.
  - ovr_clr=1 clears overrun.
  - Simultaneous set and clear: set wins.
- Config writes:
  - Write at the edge when cfg_we=1: inc[cfg_voice]<=cfg_inc, gate[cfg_voice]<=cfg_gate.
  - Writing cfg_gate=0 also clears phase[cfg_voice]<=0.
  - cfg_voice >= NUM_VOICES: write ignored, no state change.
  - Writes are accepted in any state.
- Write/sweep collision, when a cfg write targets the voice being swept in the same cycle:
  - The sweep uses the pre-write inc and gate for both its output and its phase update.
  - The stored inc and gate take the written values.
  - If cfg_gate=0, the phase clear overrides the accumulate, so the stored phase is 0. The output still shows the accumulated value.
- sample_clk_en coinciding with the DONE->IDLE edge counts as an overrun; the strobe is not accepted.

Decomposition:
- Shared package nco_pkg:
  - PHASE_W and NUM_VOICES defaults
  - voice_idx_t and phase_t typedefs
  - sched_state_t enum (IDLE, SWEEP, DONE)
- One sub-module: nco_voice_regfile. It holds the inc/gate/phase arrays, one write port for config, one read-modify-write port for the sweep, and the collision priority above.
- Scheduler FSM, index counter and output registers live in nco_voice_scheduler.

Test Plan:
- Reset, then cfg voice0 inc=0x000100 gate=1, one sample_clk_en:
  - out_valid high 8 cycles, voice 0..7 in order.
  - Voice0 phase=0x000100; others phase 0, gate 0.
  - frame_done pulses the cycle after the 8th valid.
- Wrap-around: voice3 inc=0x800000, gate=1, three sweeps -> voice3 phases 0x800000, 0x000000, 0x800000.
- Overrun:
  - sample_clk_en pulsed 3 cycles after a sweep starts -> overrun=1, still exactly 8 valids, one frame_done.
  - ovr_clr -> overrun=0.
  - ovr_clr and the overrun condition in the same cycle -> overrun stays 1.
- Collision: voice2 inc=0x10, phase=0x50.
  - Write inc=0x20 gate=1 in the cycle voice2 is swept -> out_phase=0x60; the next sweep gives 0x80.
  - Repeat with cfg_gate=0 -> out_phase=0x60, stored phase 0, next sweep output 0 with out_gate=0.
- Reset asserted mid-sweep at voice 4 -> all outputs 0 next cycle, no frame_done, all phases 0; the next sample_clk_en starts a clean sweep from voice 0.
- Invalid index: NUM_VOICES=6, cfg_voice=7 write -> no register changes, observed over a full sweep.
